dma_sram_cache_tp: RTL and testbench
====================================

# dma_sram_cache_tp

Parametrised two-port SRAM cache for the DMA controller data path, replacing the fixed 256x32 cache. It adds configurable width, depth and read latency, byte-enable writes, write-first same-address forwarding, a read-valid strobe and a hardware clear sequencer that zeroes the array after reset or on request. It sits between the DMA read engine (write side) and the DMA write engine (read side), with both on one clock.

## Interface
- DATA_W, 32: data width in bits; multiple of 8.
- ADDR_W, 8: address width.
- DEPTH, 256: number of words, ≤ 2**ADDR_W.
- OUT_REG, 1: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- CLEAR_ON_RESET, 1: 1 runs the clear sweep automatically after reset.
- CLK  in  1  sole clock; all logic is rising-edge.
- RST  in  1  reset, synchronous and active-high.
- W_DATA  in  DATA_W  write data.
- W_BE  in  DATA_W/8  byte enables; bit i covers W_DATA[8i+7:8i].
- W_ADDR  in  ADDR_W  write address.
- W_EN  in  1  write strobe.
- R_ADDR  in  ADDR_W  read address.
- R_EN  in  1  read strobe.
- R_DATA_EN  in  1  read-pipeline advance; 0 stalls the read path.
- R_DATA  out  DATA_W  read data.
- R_VALID  out  1  one-cycle strobe marking R_DATA as new read data.
- CLR_REQ  in  1  single-cycle request to start a clear sweep.
- BUSY  out  1  high while a clear sweep is in progress.

## Operation
- FSM states are IDLE and CLEAR.
- While RST is high: state IDLE, BUSY=0, R_DATA=0, R_VALID=0, clear counter 0, read pipeline emptied.
- Array contents are not reset.
- After RST: if CLEAR_ON_RESET=1, enter CLEAR on the first cycle; otherwise stay in IDLE.
- IDLE → CLEAR on CLR_REQ=1.
- CLEAR writes all-zero words to address 0..DEPTH-1, one address per cycle.
- CLEAR → IDLE after address DEPTH-1 is written. The sweep takes exactly DEPTH cycles.
- CLR_REQ is ignored while in CLEAR.
- RST in the middle of a sweep aborts it. CLEAR_ON_RESET then decides whether the sweep restarts from address 0.
- In CLEAR, user W_EN and R_EN are ignored and no new R_VALID is issued.
- Reads already in the pipeline when CLEAR starts complete normally.
- Write, IDLE only: bytes with W_BE[i]=1 are updated and other bytes are kept. W_BE=0 is a no-op.
- Read: accepted when R_EN=1, R_DATA_EN=1, in IDLE. R_EN with R_DATA_EN=0 is dropped.
- R_DATA_EN=0 freezes every read stage, including R_DATA and R_VALID.
- Same-cycle collision (accepted read, W_EN, R_ADDR==W_ADDR): read returns write-first data. Enabled bytes come from W_DATA; disabled bytes come from the old contents.
- Addresses ≥ DEPTH: writes are ignored and reads return 0 with R_VALID still asserted.
- CLR_REQ in the same cycle as W_EN in IDLE: the write executes, then the sweep starts next cycle and overwrites it.

## Timing
- Latency LAT = 1 + OUT_REG, from accepted R_EN at edge t to R_DATA/R_VALID at edge t+LAT. Stalled cycles add to this.
- Full throughput: one read and one write per cycle, with no bubbles.
- R_VALID is high for one cycle per accepted read, unless the stall holds it.
- R_DATA holds its last value when R_VALID=0.
- Write at edge t is visible to a non-colliding read accepted at edge t+1.
- BUSY rises on the cycle after the IDLE→CLEAR decision. It falls DEPTH cycles later, and a user write is accepted in that same cycle.

## Structure
- Package dma_cache_pkg holds:
  - the state enum (ST_IDLE, ST_CLEAR);
  - a function returning LAT from OUT_REG;
  - a function returning byte-lane count from DATA_W.
- Sub-module dma_sram_tp_array is a behavioural DEPTH x DATA_W two-port array. It has a byte-write port and a registered synchronous read port, is inferable as RAM1K20 blocks, and has no reset.
- The top level holds the FSM, clear counter, write mux (clear vs user), collision forwarding, optional output stage and valid pipeline.

## Test plan
- Reset-clear: CLEAR_ON_RESET=1, DEPTH=256, after RST → BUSY high for exactly 256 cycles; then reads of addresses 0, 0x7F and 0xFF return 0 with R_VALID at t+2.
- Byte enables: write 0xAABBCCDD to addr 5, then write 0x11223344 with W_BE=4'b0101 → read gives 0xAA22CC44.
- Collision: addr 9 holds 0x0; same cycle W_EN with 0xDEADBEEF, W_BE=4'b1100 and R_EN on addr 9 → R_DATA=0xDEAD0000.
- Stall: R_EN on addrs 1, 2, 3 back-to-back with R_DATA_EN=0 for 2 cycles after the first → three R_VALID pulses, data in order, R_DATA held during the stall. Repeat with OUT_REG=0 to check latency 1.
- Mid-sweep: CLR_REQ, RST asserted at sweep cycle 100 → BUSY restarts and runs the full 256 cycles. With CLEAR_ON_RESET=0 → BUSY=0 and earlier contents beyond addr 99 are preserved.
- Out of range: DEPTH=200, ADDR_W=8; write 0x5 to addr 210 → no array change; read of addr 210 gives 0 with R_VALID=1.

Source files
------------

// File: rtl/dma_sram_cache_tp_pkg.sv
// Shared types and helpers for the DMA two-port SRAM cache.
package dma_cache_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int unsigned BYTE_W = 8;

    // Read latency in cycles: array register plus optional output register.
    function automatic int unsigned lat_of(input int unsigned out_reg);
        return (out_reg != 0) ? 32'd2 : 32'd1;
    endfunction

    // Number of byte lanes in a data word.
    function automatic int unsigned lanes_of(input int unsigned data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/dma_sram_cache_tp_if.sv
// Write/read/clear bus of the DMA two-port SRAM cache.
interface dma_sram_cache_tp_if
    import dma_cache_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic [DATA_W-1:0]                W_DATA;
    logic [lanes_of(DATA_W)-1:0]      W_BE;
    logic [ADDR_W-1:0]                W_ADDR;
    logic                             W_EN;
    logic [ADDR_W-1:0]                R_ADDR;
    logic                             R_EN;
    logic                             R_DATA_EN;
    logic [DATA_W-1:0]                R_DATA;
    logic                             R_VALID;
    logic                             CLR_REQ;
    logic                             BUSY;

    modport master (
        output W_DATA, W_BE, W_ADDR, W_EN, R_ADDR, R_EN, R_DATA_EN, CLR_REQ,
        input  R_DATA, R_VALID, BUSY
    );

    modport slave (
        input  W_DATA, W_BE, W_ADDR, W_EN, R_ADDR, R_EN, R_DATA_EN, CLR_REQ,
        output R_DATA, R_VALID, BUSY
    );
endinterface

// File: rtl/dma_sram_tp_array.sv
// Behavioural DEPTH x DATA_W two-port RAM: byte-write port, registered read port, no reset.
module dma_sram_tp_array
    import dma_cache_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           waddr,
    input  logic [lanes_of(DATA_W)-1:0] wbe,
    input  logic [DATA_W-1:0]           wdata,
    input  logic                        re,
    input  logic [ADDR_W-1:0]           raddr,
    output logic [DATA_W-1:0]           rdata
);
    localparam int unsigned NB = lanes_of(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write; read register returns pre-write contents on a same-address hit.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dma_sram_cache_tp.sv
// DMA two-port SRAM cache: clear sequencer, write mux, collision forwarding, read pipeline.
module dma_sram_cache_tp
    import dma_cache_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 256,
    parameter int OUT_REG        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                CLK,
    input  logic                RST,
    dma_sram_cache_tp_if.slave  bus
);
    localparam int unsigned      NB        = lanes_of(DATA_W);
    localparam int unsigned      LAT       = lat_of(OUT_REG);
    localparam logic [ADDR_W:0]  DEPTH_W   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_cnt;
    logic                init_pend;

    logic                idle, w_in_range, r_in_range, user_we, accept, collide;
    logic                arr_we;
    logic [ADDR_W-1:0]   arr_waddr;
    logic [NB-1:0]       arr_wbe;
    logic [DATA_W-1:0]   arr_wdata;
    logic [DATA_W-1:0]   ram_q;

    logic                valid1, oor1, col1;
    logic [DATA_W-1:0]   fwd_data1;
    logic [NB-1:0]       fwd_be1;
    logic [DATA_W-1:0]   stage1_data;

    assign idle       = (state == ST_IDLE);
    assign w_in_range = ({1'b0, bus.W_ADDR} < DEPTH_W);
    assign r_in_range = ({1'b0, bus.R_ADDR} < DEPTH_W);
    assign user_we    = idle && bus.W_EN && w_in_range && !RST;
    assign accept     = idle && bus.R_EN && bus.R_DATA_EN && !RST;
    assign collide    = accept && user_we && (bus.R_ADDR == bus.W_ADDR);
    assign bus.BUSY   = (state == ST_CLEAR);

    // State register, clear address counter and one-shot post-reset sweep trigger.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            clr_cnt   <= '0;
            init_pend <= 1'b1;
        end else begin
            state     <= state_nxt;
            init_pend <= 1'b0;
            if (state == ST_CLEAR) begin
                clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + 1'b1;
            end
        end
    end

    // Next-state: start a sweep on request (or after reset), finish after the last address.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.CLR_REQ || ((CLEAR_ON_RESET != 0) && init_pend)) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write port mux: the sweep owns the array while clearing, the user otherwise.
    always_comb begin
        arr_we    = user_we;
        arr_waddr = bus.W_ADDR;
        arr_wbe   = bus.W_BE;
        arr_wdata = bus.W_DATA;
        if (state == ST_CLEAR) begin
            arr_we    = !RST;
            arr_waddr = clr_cnt;
            arr_wbe   = '1;
            arr_wdata = '0;
        end
    end

    dma_sram_tp_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (CLK),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wbe   (arr_wbe),
        .wdata (arr_wdata),
        .re    (accept && r_in_range),
        .raddr (bus.R_ADDR),
        .rdata (ram_q)
    );

    // Stage 1 sideband: valid, out-of-range and collision info travel alongside the array read.
    // oor1 resets high so the unreset array register never reaches R_DATA before the first read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid1    <= 1'b0;
            oor1      <= 1'b1;
            col1      <= 1'b0;
            fwd_data1 <= '0;
            fwd_be1   <= '0;
        end else if (bus.R_DATA_EN) begin
            valid1 <= accept;
            if (accept) begin
                oor1      <= !r_in_range;
                col1      <= collide;
                fwd_data1 <= bus.W_DATA;
                fwd_be1   <= bus.W_BE;
            end
        end
    end

    // Write-first merge of colliding bytes over the old word; out-of-range reads give zero.
    always_comb begin
        stage1_data = ram_q;
        for (int unsigned i = 0; i < NB; i++) begin
            if (col1 && fwd_be1[i]) begin
                stage1_data[8*i +: 8] = fwd_data1[8*i +: 8];
            end
        end
        if (oor1) begin
            stage1_data = '0;
        end
    end

    if (LAT == 32'd2) begin : g_out_reg
        logic [DATA_W-1:0] out_data;
        logic              out_valid;

        // Output register: loads only on new data, holds otherwise, freezes on stall.
        always_ff @(posedge CLK) begin
            if (RST) begin
                out_data  <= '0;
                out_valid <= 1'b0;
            end else if (bus.R_DATA_EN) begin
                out_valid <= valid1;
                if (valid1) begin
                    out_data <= stage1_data;
                end
            end
        end

        assign bus.R_DATA  = out_data;
        assign bus.R_VALID = out_valid;
    end else begin : g_no_out_reg
        assign bus.R_DATA  = stage1_data;
        assign bus.R_VALID = valid1;
    end

endmodule

// File: tb/tb_dma_sram_cache_tp.sv
// Directed self-checking bench: dut_a = 256 deep, 2-cycle latency, auto clear;
// dut_b = 200 deep, 1-cycle latency, no auto clear.
module tb_dma_sram_cache_tp;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dma_sram_cache_tp_if #(.DATA_W(32), .ADDR_W(8)) if_a ();
    dma_sram_cache_tp_if #(.DATA_W(32), .ADDR_W(8)) if_b ();

    dma_sram_cache_tp #(
        .DATA_W(32), .ADDR_W(8), .DEPTH(256), .OUT_REG(1), .CLEAR_ON_RESET(1)
    ) dut_a (.CLK(clk), .RST(rst_a), .bus(if_a));

    dma_sram_cache_tp #(
        .DATA_W(32), .ADDR_W(8), .DEPTH(200), .OUT_REG(0), .CLEAR_ON_RESET(0)
    ) dut_b (.CLK(clk), .RST(rst_b), .bus(if_b));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] get_data(input bit b);
        return b ? if_b.R_DATA : if_a.R_DATA;
    endfunction

    function automatic logic get_valid(input bit b);
        return b ? if_b.R_VALID : if_a.R_VALID;
    endfunction

    function automatic logic get_busy(input bit b);
        return b ? if_b.BUSY : if_a.BUSY;
    endfunction

    task automatic drive_rd(input bit b, input logic en, input logic [7:0] addr, input logic de);
        if (b) begin if_b.R_EN = en; if_b.R_ADDR = addr; if_b.R_DATA_EN = de; end
        else   begin if_a.R_EN = en; if_a.R_ADDR = addr; if_a.R_DATA_EN = de; end
    endtask

    task automatic drive_wr(input bit b, input logic en, input logic [7:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
        if (b) begin if_b.W_EN = en; if_b.W_ADDR = addr; if_b.W_DATA = data; if_b.W_BE = be; end
        else   begin if_a.W_EN = en; if_a.W_ADDR = addr; if_a.W_DATA = data; if_a.W_BE = be; end
    endtask

    task automatic drive_clr(input bit b, input logic v);
        if (b) if_b.CLR_REQ = v; else if_a.CLR_REQ = v;
    endtask

    task automatic wr(input bit b, input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        drive_wr(b, 1'b1, addr, data, be);
        step();
        drive_wr(b, 1'b0, 8'h00, 32'h0, 4'h0);
    endtask

    // Called at the negedge right after the accepting edge.
    task automatic rd_check(input bit b, input logic [31:0] exp, input int lat, input string tag);
        for (int k = 1; k < lat; k++) begin
            check_eq({tag, "_early"}, {31'b0, get_valid(b)}, 32'h0);
            step();
        end
        check_eq({tag, "_valid"}, {31'b0, get_valid(b)}, 32'h1);
        check_eq({tag, "_data"}, get_data(b), exp);
        step();
        check_eq({tag, "_strobe"}, {31'b0, get_valid(b)}, 32'h0);
    endtask

    task automatic rd(input bit b, input logic [7:0] addr, input logic [31:0] exp, input int lat, input string tag);
        drive_rd(b, 1'b1, addr, 1'b1);
        step();
        drive_rd(b, 1'b0, 8'h00, 1'b1);
        rd_check(b, exp, lat, tag);
    endtask

    // Counts consecutive BUSY-high samples starting at the current negedge.
    task automatic count_busy(input bit b, output int n);
        n = 0;
        while (get_busy(b) && n < 1000) begin
            n++;
            step();
        end
    endtask

    // Stall vectors: read 1, hold off two cycles, then reads 2 and 3.
    logic       st_en   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] st_addr [7] = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd3, 8'd0, 8'd0};
    logic       st_de   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       st_va_a [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] st_d_a [7] = '{32'hDEAD0000, 32'hDEAD0000, 32'hDEAD0000,
                                32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 32'h0000_3333};
    logic       st_va_b [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] st_d_b [7] = '{32'h0000_1111, 32'h0000_1111, 32'h0000_1111,
                                32'h0000_2222, 32'h0000_3333, 32'h0000_3333, 32'h0000_3333};

    task automatic stall_test(input bit b);
        wr(b, 8'd1, 32'h0000_1111, 4'hF);
        wr(b, 8'd2, 32'h0000_2222, 4'hF);
        wr(b, 8'd3, 32'h0000_3333, 4'hF);
        for (int i = 0; i < 7; i++) begin
            drive_rd(b, st_en[i], st_addr[i], st_de[i]);
            step();
            check_eq($sformatf("stall%0d_valid_%0d", b, i), {31'b0, get_valid(b)},
                     {31'b0, (b ? st_va_b[i] : st_va_a[i])});
            check_eq($sformatf("stall%0d_data_%0d", b, i), get_data(b),
                     (b ? st_d_b[i] : st_d_a[i]));
        end
        drive_rd(b, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic collide_test(input bit b, input int lat);
        drive_wr(b, 1'b1, 8'd9, 32'hDEADBEEF, 4'b1100);
        drive_rd(b, 1'b1, 8'd9, 1'b1);
        step();
        drive_wr(b, 1'b0, 8'h00, 32'h0, 4'h0);
        drive_rd(b, 1'b0, 8'h00, 1'b1);
        rd_check(b, 32'hDEAD0000, lat, $sformatf("coll%0d", b));
        rd(b, 8'd9, 32'hDEAD0000, lat, $sformatf("coll%0d_after", b));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_wr(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        drive_wr(1'b1, 1'b0, 8'h00, 32'h0, 4'h0);
        drive_rd(1'b0, 1'b0, 8'h00, 1'b1);
        drive_rd(1'b1, 1'b0, 8'h00, 1'b1);
        drive_clr(1'b0, 1'b0);
        drive_clr(1'b1, 1'b0);
        repeat (3) step();

        check_eq("rst_a_busy",  {31'b0, if_a.BUSY},    32'h0);
        check_eq("rst_a_valid", {31'b0, if_a.R_VALID}, 32'h0);
        check_eq("rst_a_data",  if_a.R_DATA,           32'h0);
        check_eq("rst_b_busy",  {31'b0, if_b.BUSY},    32'h0);
        check_eq("rst_b_valid", {31'b0, if_b.R_VALID}, 32'h0);
        check_eq("rst_b_data",  if_b.R_DATA,           32'h0);

        // Release: dut_a sweeps on its own, dut_b stays idle.
        rst_a = 1'b0;
        rst_b = 1'b0;
        step();
        check_eq("b_no_auto_clear", {31'b0, if_b.BUSY}, 32'h0);
        count_busy(1'b0, n);
        check_eq("a_reset_sweep_len", n, 256);

        // Requested sweep on dut_b.
        drive_clr(1'b1, 1'b1);
        step();
        drive_clr(1'b1, 1'b0);
        count_busy(1'b1, n);
        check_eq("b_req_sweep_len", n, 200);

        rd(1'b0, 8'h00, 32'h0, 2, "a_clr_00");
        rd(1'b0, 8'h7F, 32'h0, 2, "a_clr_7f");
        rd(1'b0, 8'hFF, 32'h0, 2, "a_clr_ff");

        // Byte enables on both latencies, plus an all-zero enable no-op.
        wr(1'b0, 8'd5, 32'hAABBCCDD, 4'hF);
        wr(1'b0, 8'd5, 32'h11223344, 4'b0101);
        rd(1'b0, 8'd5, 32'hAA22CC44, 2, "a_be");
        wr(1'b0, 8'd5, 32'hFFFFFFFF, 4'b0000);
        rd(1'b0, 8'd5, 32'hAA22CC44, 2, "a_be_zero");
        wr(1'b1, 8'd5, 32'hAABBCCDD, 4'hF);
        wr(1'b1, 8'd5, 32'h11223344, 4'b0101);
        rd(1'b1, 8'd5, 32'hAA22CC44, 1, "b_be");

        collide_test(1'b0, 2);
        collide_test(1'b1, 1);

        stall_test(1'b0);
        stall_test(1'b1);

        // dut_b: reset 100 cycles into a sweep, no restart, upper contents kept.
        wr(1'b1, 8'd150, 32'hCAFEF00D, 4'hF);
        wr(1'b1, 8'd50,  32'h12345678, 4'hF);
        drive_clr(1'b1, 1'b1);
        step();
        drive_clr(1'b1, 1'b0);
        check_eq("b_mid_busy", {31'b0, if_b.BUSY}, 32'h1);
        repeat (100) step();
        rst_b = 1'b1;
        repeat (2) step();
        rst_b = 1'b0;
        repeat (3) step();
        check_eq("b_mid_no_restart", {31'b0, if_b.BUSY}, 32'h0);
        rd(1'b1, 8'd150, 32'hCAFEF00D, 1, "b_mid_kept150");
        rd(1'b1, 8'd50,  32'h0,        1, "b_mid_clr50");

        // dut_a: reset 100 cycles into a sweep restarts a full sweep.
        wr(1'b0, 8'd150, 32'hCAFEF00D, 4'hF);
        drive_clr(1'b0, 1'b1);
        step();
        drive_clr(1'b0, 1'b0);
        repeat (100) step();
        rst_a = 1'b1;
        repeat (2) step();
        rst_a = 1'b0;
        step();
        count_busy(1'b0, n);
        check_eq("a_mid_restart_len", n, 256);
        rd(1'b0, 8'd150, 32'h0, 2, "a_mid_clr150");

        // dut_b out of range (DEPTH=200): last valid address works, 210 ignored.
        wr(1'b1, 8'd199, 32'h0000_0005, 4'hF);
        wr(1'b1, 8'd210, 32'h0000_0005, 4'hF);
        rd(1'b1, 8'd199, 32'h0000_0005, 1, "b_last_addr");
        rd(1'b1, 8'd210, 32'h0,         1, "b_oor_read");
        rd(1'b1, 8'd10,  32'h0,         1, "b_oor_alias");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
